// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the alignment rule used at command accept.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_e;

  // Undefined width codes fall into the default branch and align as words.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      default:     mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'h000000, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'h0000, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// EX->MEM load/store controller: single-outstanding req/ack memory port with
// byte-lane steering, load extension, misalignment and timeout reporting.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | request on the memory port, waiting for ack or timeout
// DONE  | one-cycle completion, result flags valid
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_is_store,
  input  logic [2:0]   i_funct3,
  input  logic [N-1:0] i_addr,
  input  logic [N-1:0] i_wdata,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [N-1:0] o_mem_addr,
  output logic [N-1:0] o_mem_wdata,
  output logic [3:0]   o_mem_be,
  input  logic         i_mem_ack,
  input  logic [N-1:0] i_mem_rdata,
  output logic         o_done,
  output logic [N-1:0] o_ld_data,
  output logic         o_misaligned,
  output logic         o_bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e state, state_nxt;

  logic         cmd_store;
  logic [2:0]   cmd_f3;
  logic [N-1:0] cmd_addr;
  logic [N-1:0] cmd_wdata;
  logic [7:0]   wait_cnt;
  logic [N-1:0] ld_q;
  logic         mis_q;
  logic         err_q;

  logic         accept;
  logic         mis_in;
  logic         timeout;
  logic [N-1:0] ld_ext;
  logic [3:0]   be_lane;
  logic [N-1:0] wdata_lane;

  assign accept  = i_valid && (state == IDLE);
  assign mis_in  = is_misaligned(i_funct3, i_addr[1:0]);
  assign timeout = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = mis_in ? DONE : REQ;
      REQ:  if (i_mem_ack || timeout) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cmd_store <= 1'b0;
      cmd_f3    <= 3'b000;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (accept) begin
      cmd_store <= i_is_store;
      cmd_f3    <= i_funct3;
      cmd_addr  <= i_addr;
      cmd_wdata <= i_wdata;
    end
  end

  // Counts unacknowledged REQ cycles; reaching WAIT_LAST means MAX_WAIT cycles elapsed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= 8'd0;
    end else if ((state == REQ) && !i_mem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  lsu_load_align u_load_align (
    .rdata   (i_mem_rdata),
    .addr_lo (cmd_addr[1:0]),
    .funct3  (cmd_f3),
    .ld_data (ld_ext)
  );

  // Result flags are computed on entry to DONE; the load value then holds until the next completion.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ld_q  <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mis_q <= (state == IDLE) && (state_nxt == DONE);
      err_q <= (state == REQ) && !i_mem_ack && timeout;
      if ((state != DONE) && (state_nxt == DONE)) begin
        ld_q <= ((state == REQ) && i_mem_ack && !cmd_store) ? ld_ext : '0;
      end
    end
  end

  always_comb begin
    case (cmd_f3)
      F3_B, F3_BU: begin
        be_lane    = 4'b0001 << cmd_addr[1:0];
        wdata_lane = {4{cmd_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be_lane    = 4'b0011 << cmd_addr[1:0];
        wdata_lane = {2{cmd_wdata[15:0]}};
      end
      default: begin
        be_lane    = 4'b1111;
        wdata_lane = cmd_wdata;
      end
    endcase
  end

  assign o_ready      = (state == IDLE);
  assign o_mem_req    = (state == REQ);
  assign o_mem_we     = o_mem_req && cmd_store;
  assign o_mem_addr   = o_mem_req ? {cmd_addr[N-1:2], 2'b00} : '0;
  assign o_mem_wdata  = o_mem_req ? wdata_lane : '0;
  assign o_mem_be     = o_mem_req ? be_lane : 4'b0000;
  assign o_done       = (state == DONE);
  assign o_ld_data    = ld_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl: the driver queues expected requests
// and completions, a negedge monitor compares whatever the DUT presents.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic [31:0] o_ld_data;
  logic        o_misaligned;
  logic        o_bus_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        err;
    int          at_cyc;
    int          reqc;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  lsu_ctrl #(.N(32), .MAX_WAIT(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_is_store   (i_is_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_done       (o_done),
    .o_ld_data    (o_ld_data),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor
  int   req_cnt  = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    done_t d;
    if (rst) begin
      req_cnt  = 0;
      prev_req = 1'b0;
    end else begin
      if (o_mem_req) begin
        req_cnt++;
        if (req_q.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          chk("mem_addr", o_mem_addr, req_q[0].addr);
          chk("mem_wdata", o_mem_wdata, req_q[0].wdata);
          chk("mem_we", 32'(o_mem_we), 32'(req_q[0].we));
          chk("mem_be", 32'(o_mem_be), 32'(req_q[0].be));
        end
      end else if (prev_req && (req_q.size() > 0)) begin
        void'(req_q.pop_front());
      end
      prev_req = o_mem_req;
      if (o_done) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          d = done_q.pop_front();
          chk("ld_data", o_ld_data, d.ld);
          chk("misaligned", 32'(o_misaligned), 32'(d.mis));
          chk("bus_err", 32'(o_bus_err), 32'(d.err));
          chk("done_cycle", 32'(cyc), 32'(d.at_cyc));
          chk("req_cycles", 32'(req_cnt), 32'(d.reqc));
        end
        req_cnt = 0;
      end
    end
  end

  // k = REQ cycle on which ack is driven (1 = first); 0 = never ack.
  task automatic run_cmd(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                         input logic [3:0] be, input logic [31:0] mwdata, input logic [31:0] ld,
                         input logic mis, input logic err);
    req_t  r;
    done_t d;
    int    acc;
    int    reqc;
    int    n;
    @(negedge clk);
    chk("ready_idle", 32'(o_ready), 32'd1);
    reqc = mis ? 0 : ((k == 0) ? 16 : k);
    i_valid    = 1'b1;
    i_is_store = st;
    i_funct3   = f3;
    i_addr     = addr;
    i_wdata    = wdata;
    acc        = cyc + 1;
    if (!mis) begin
      r.addr  = addr & 32'hFFFF_FFFC;
      r.wdata = mwdata;
      r.we    = st;
      r.be    = be;
      req_q.push_back(r);
    end
    d.ld     = ld;
    d.mis    = mis;
    d.err    = err;
    d.at_cyc = acc + reqc;
    d.reqc   = reqc;
    done_q.push_back(d);
    @(negedge clk);
    i_valid    = 1'b0;
    i_is_store = ~st;
    i_funct3   = 3'b111;
    i_addr     = 32'hFFFF_FFFF;
    i_wdata    = ~wdata;
    chk("ready_busy", 32'(o_ready), 32'd0);
    if (!mis && (k > 0)) begin
      repeat (k - 1) @(negedge clk);
      i_mem_ack   = 1'b1;
      i_mem_rdata = rdata;
      @(negedge clk);
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h5A5A_5A5A;
    end
    n = 0;
    while (!o_ready && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) fail_now("wait_idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_is_store  = 1'b0;
    i_funct3    = 3'b000;
    i_addr      = 32'h0;
    i_wdata     = 32'h0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h5A5A_5A5A;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wdata", o_mem_wdata, 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ld", o_ld_data, 32'd0);
    chk("rst_mis", 32'(o_misaligned), 32'd0);
    chk("rst_err", 32'(o_bus_err), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    //      st    f3      addr          wdata         rdata         k   be       mwdata        ld            mis   err
    run_cmd(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0);
    // stray ack while idle must be ignored
    @(negedge clk); i_mem_ack = 1'b1; @(negedge clk); i_mem_ack = 1'b0;
    run_cmd(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 2, 4'b1100, 32'h0,        32'h0000_BEEF, 1'b0, 1'b0);
    run_cmd(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 1, 4'b1100, 32'h0,        32'hFFFF_BEEF, 1'b0, 1'b0);
    run_cmd(1'b0, 3'b010, 32'h0000_0202, 32'h0,        32'h0,         1, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0);
    run_cmd(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0);
    run_cmd(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0,        0, 4'b1111, 32'h1234_5678, 32'h0,        1'b0, 1'b1);
    run_cmd(1'b1, 3'b010, 32'h0000_0304, 32'h9ABC_DEF0, 32'h0,       16, 4'b1111, 32'h9ABC_DEF0, 32'h0,        1'b0, 1'b0);
    run_cmd(1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_8A00, 3, 4'b0010, 32'h0,        32'h0000_008A, 1'b0, 1'b0);
    run_cmd(1'b1, 3'b001, 32'h0000_0002, 32'hCAFE_BEEF, 32'h0,        1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0);
    run_cmd(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 2, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0);
    run_cmd(1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        1, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0);
    run_cmd(1'b0, 3'b110, 32'h0000_0008, 32'h0,        32'h89AB_CDEF, 1, 4'b1111, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0);
    run_cmd(1'b0, 3'b011, 32'h0000_0009, 32'h0,        32'h0,         1, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0);
    run_cmd(1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 1, 4'b0001, 32'h0,        32'h0000_007F, 1'b0, 1'b0);
    run_cmd(1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h7FFF_0000, 1, 4'b1100, 32'h0,        32'h0000_7FFF, 1'b0, 1'b0);

    // asynchronous reset while a store is waiting for ack
    @(negedge clk);
    begin
      req_t r;
      r.addr  = 32'h0000_0400;
      r.wdata = 32'h0000_0011;
      r.we    = 1'b1;
      r.be    = 4'b1111;
      req_q.push_back(r);
    end
    i_valid    = 1'b1;
    i_is_store = 1'b1;
    i_funct3   = 3'b010;
    i_addr     = 32'h0000_0400;
    i_wdata    = 32'h0000_0011;
    @(negedge clk);
    i_valid = 1'b0;
    chk("pre_rst_req", 32'(o_mem_req), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(o_mem_req), 32'd0);
    chk("async_rst_ready", 32'(o_ready), 32'd1);
    chk("async_rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    req_q.delete();

    run_cmd(1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8001, 1, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0);
    run_cmd(1'b1, 3'b000, 32'h0000_0003, 32'h1234_5677, 32'h0,        1, 4'b1000, 32'h7777_7777, 32'h0,        1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
